// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control sequencer for the 16-bit datapath. Each instruction is
// walked through FETCH/DECODE/EXEC/[MEM]/WB. The datapath control strobes are
// a Moore decode of the current state and the opcode latched in DECODE. MEM
// stalls on the data-memory ready handshake. Retired instructions are counted.
//
// Optional feature macro: MULTICYCLE_CTRL_MEM_TIMEOUT_EN
//   defined   : MEM waits at most MEM_TIMEOUT cycles. Past that limit the
//               block enters a sticky ERR state and err=1 until reset.
//   undefined : MEM waits indefinitely, err is tied 0 and ERR is unreachable.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset; returns the block to IDLE
//   run          level enable for instruction sequencing
//   opcode       IR[15:14]: 00=R-format, 01=addi, 10=lw, 11=sw
//   mem_ready    data memory has completed the current read/write
//   pc_we        PC <= PC+1
//   ir_we        instruction register load
//   RegDst       1=write RD, 0=write RT
//   ALUSrc       0=RD2, 1=sign-extended immediate
//   MemToReg     write-back from data memory
//   RegWrite     register file write enable
//   MemRead      data memory read strobe
//   MemWrite     data memory write strobe
//   ALUOp        00=add, 10=decode funct
//   state        current state code
//   instr_done   one-cycle retire pulse
//   instr_count  retired instruction count (wraps)
//   err          memory timeout error
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       ALUOp,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [1:0]       OP_R    = 2'b00;
  localparam logic [1:0]       OP_LW   = 2'b10;
  localparam logic [1:0]       OP_SW   = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Elaboration-time sanity check on the timeout limit.
  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be at least 1");
  end

  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] count_r;
  logic             retire_s;

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
  localparam int             TW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]  WAIT_ONE  = TW'(1);
  localparam logic [TW-1:0]  WAIT_LIM  = TW'(MEM_TIMEOUT);
  logic [TW-1:0] wait_r;
  logic [TW-1:0] wait_nxt_s;
  logic [TW-1:0] wait_inc_s;
  assign wait_inc_s = wait_r + WAIT_ONE;
`endif

  // Next-state decode and retire detection.
  always_comb begin
    state_nxt_s = state_r;
    retire_s    = 1'b0;
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    wait_nxt_s  = wait_r;
`endif
    case (state_r)
      IDLE: begin
        if (run) state_nxt_s = FETCH;
        else     state_nxt_s = IDLE;
      end
      FETCH:  state_nxt_s = DECODE;
      DECODE: state_nxt_s = EXEC;
      EXEC: begin
        if (op_r == OP_LW || op_r == OP_SW) begin
          state_nxt_s = MEM;
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
          wait_nxt_s  = '0;
`endif
        end else begin
          state_nxt_s = WB;
        end
      end
      MEM: begin
        if (mem_ready) begin
          // A store finishes here; a load still has to write back.
          if (op_r == OP_SW) begin
            retire_s    = 1'b1;
            state_nxt_s = run ? FETCH : IDLE;
          end else begin
            state_nxt_s = WB;
          end
        end else begin
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
          // mem_ready=1 on the limit edge takes the branch above instead.
          wait_nxt_s = wait_inc_s;
          if (wait_inc_s == WAIT_LIM) state_nxt_s = ERR;
          else                        state_nxt_s = MEM;
`else
          state_nxt_s = MEM;
`endif
        end
      end
      WB: begin
        retire_s    = 1'b1;
        state_nxt_s = run ? FETCH : IDLE;
      end
      ERR:     state_nxt_s = ERR;
      default: state_nxt_s = IDLE;   // unused code 7 recovers to IDLE
    endcase
  end

  // State, latched opcode, retire counter and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      op_r    <= 2'b00;
      count_r <= '0;
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
      wait_r  <= '0;
`endif
    end else begin
      state_r <= state_nxt_s;
      if (state_r == DECODE) op_r <= opcode;
      if (retire_s) count_r <= count_r + CNT_ONE;
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
      wait_r  <= wait_nxt_s;
`endif
    end
  end

  // Moore strobe decode from state and latched opcode.
  always_comb begin
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = 2'b00;
    case (state_r)
      FETCH: begin
        pc_we = 1'b1;
        ir_we = 1'b1;
      end
      EXEC: begin
        ALUSrc = (op_r != OP_R);
        ALUOp  = (op_r == OP_R) ? 2'b10 : 2'b00;
      end
      MEM: begin
        ALUSrc   = 1'b1;
        MemRead  = (op_r == OP_LW);
        MemWrite = (op_r == OP_SW);
      end
      WB: begin
        // ALU controls hold their EXEC values so the result stays stable.
        ALUSrc   = (op_r != OP_R);
        ALUOp    = (op_r == OP_R) ? 2'b10 : 2'b00;
        RegWrite = 1'b1;
        RegDst   = (op_r == OP_R);
        MemToReg = (op_r == OP_LW);
      end
      default: begin
        pc_we = 1'b0;
      end
    endcase
  end

  assign state       = state_r;
  assign instr_done  = retire_s;
  assign instr_count = count_r;
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
  assign err = (state_r == ERR);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl: a per-cycle vector table covering R,
// lw with wait states, sw, and run dropped mid-instruction, followed by
// hand-written sequences for async reset mid-MEM, counter wrap and MEM
// timeout behaviour.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int CNT_W = 3;

  // Strobe packing: {pc_we, ir_we, RegDst, ALUSrc, MemToReg, RegWrite,
  //                  MemRead, MemWrite, ALUOp[1:0]}
  localparam logic [9:0] S_NONE  = 10'b00_0000_0000;
  localparam logic [9:0] S_FETCH = 10'b11_0000_0000;
  localparam logic [9:0] S_EX_R  = 10'b00_0000_0010;
  localparam logic [9:0] S_EX_I  = 10'b00_0100_0000;
  localparam logic [9:0] S_M_LW  = 10'b00_0100_1000;
  localparam logic [9:0] S_M_SW  = 10'b00_0100_0100;
  localparam logic [9:0] S_WB_R  = 10'b00_1001_0010;
  localparam logic [9:0] S_WB_AD = 10'b00_0101_0000;
  localparam logic [9:0] S_WB_LW = 10'b00_0111_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic [1:0]       opcode;
  logic             mem_ready;
  logic             pc_we, ir_we, RegDst, ALUSrc, MemToReg, RegWrite;
  logic             MemRead, MemWrite;
  logic [1:0]       ALUOp;
  logic [2:0]       state;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic             err;
  logic [9:0]       strobes;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .state(state),
    .instr_done(instr_done), .instr_count(instr_count), .err(err)
  );

  assign strobes = {pc_we, ir_we, RegDst, ALUSrc, MemToReg, RegWrite,
                    MemRead, MemWrite, ALUOp};

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             run;
    logic [1:0]       op;
    logic             mr;
    logic [2:0]       st;
    logic [9:0]       strb;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic rn, logic [1:0] op, logic mr,
                              logic [2:0] st, logic [9:0] strb, logic done,
                              logic [CNT_W-1:0] cnt);
    vec_t v;
    v.rst = rst; v.run = rn; v.op = op; v.mr = mr;
    v.st = st; v.strb = strb; v.done = done; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input string name);
    int c = 0;
    while (state !== target && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    chk(name, {29'd0, state}, {29'd0, target});
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; opcode = 2'b00; mem_ready = 1'b0;

    //             rst   run   op     mr    st    strobes  done  cnt
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, S_NONE,  1'b0, 3'd0));
    // R-format
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 1'b1, 3'd0, S_NONE,  1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 1'b1, 3'd1, S_FETCH, 1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 1'b1, 3'd2, S_NONE,  1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b1, 3'd3, S_EX_R,  1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b1, 3'd5, S_WB_R,  1'b1, 3'd0));
    // lw with three wait cycles
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 3'd1, S_FETCH, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 3'd2, S_NONE,  1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 3'd3, S_EX_I,  1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 3'd4, S_M_LW,  1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 3'd4, S_M_LW,  1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 3'd4, S_M_LW,  1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b1, 3'd4, S_M_LW,  1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b1, 3'd5, S_WB_LW, 1'b1, 3'd1));
    // sw, zero wait states
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b1, 3'd1, S_FETCH, 1'b0, 3'd2));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b1, 3'd2, S_NONE,  1'b0, 3'd2));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b1, 3'd3, S_EX_I,  1'b0, 3'd2));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b1, 3'd4, S_M_SW,  1'b1, 3'd2));
    // addi with run dropped in EXEC (opcode change is ignored)
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b1, 3'd1, S_FETCH, 1'b0, 3'd3));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b1, 3'd2, S_NONE,  1'b0, 3'd3));
    vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b1, 3'd3, S_EX_I,  1'b0, 3'd3));
    vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b1, 3'd5, S_WB_AD, 1'b1, 3'd3));
    vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b1, 3'd0, S_NONE,  1'b0, 3'd4));
    vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b1, 3'd0, S_NONE,  1'b0, 3'd4));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; run = vecs[i].run;
      opcode = vecs[i].op; mem_ready = vecs[i].mr;
      #1;
      chk($sformatf("v%0d state", i),   {29'd0, state},       {29'd0, vecs[i].st});
      chk($sformatf("v%0d strobes", i), {22'd0, strobes},     {22'd0, vecs[i].strb});
      chk($sformatf("v%0d done", i),    {31'd0, instr_done},  {31'd0, vecs[i].done});
      chk($sformatf("v%0d count", i),   {29'd0, instr_count}, {29'd0, vecs[i].cnt});
      chk($sformatf("v%0d err", i),     {31'd0, err},         32'd0);
    end

    // Async reset in the middle of a sw MEM stall.
    run = 1'b1; opcode = 2'b11; mem_ready = 1'b0;
    wait_state(3'd4, "sw reach MEM");
    chk("sw MemWrite before reset", {31'd0, MemWrite}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("reset MemWrite", {31'd0, MemWrite}, 32'd0);
    chk("reset state", {29'd0, state}, 32'd0);
    chk("reset count", {29'd0, instr_count}, 32'd0);

    // Back-to-back R-format until the counter wraps.
    @(negedge clk);
    reset = 1'b0; run = 1'b1; opcode = 2'b00; mem_ready = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 200 && seen < 8; c++) begin
        @(negedge clk); #1;
        if (instr_done) seen++;
      end
      chk("wrap retire count", seen, 32'd8);
    end
    chk("count before wrap", {29'd0, instr_count}, 32'd7);
    @(negedge clk); #1;
    chk("count wrapped", {29'd0, instr_count}, 32'd0);
    chk("refetch after retire", {29'd0, state}, 32'd1);

    // lw with mem_ready held low.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; run = 1'b1; opcode = 2'b10; mem_ready = 1'b0;
    #1;
    wait_state(3'd4, "lw reach MEM");
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk); #1;
      chk($sformatf("wait cycle %0d state", k), {29'd0, state}, 32'd4);
    end
    @(negedge clk); #1;
    chk("timeout state", {29'd0, state}, 32'd6);
    chk("timeout err", {31'd0, err}, 32'd1);
    chk("timeout strobes", {22'd0, strobes}, 32'd0);
    mem_ready = 1'b1; run = 1'b0;
    repeat (3) @(negedge clk);
    run = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("ERR sticky state", {29'd0, state}, 32'd6);
    chk("ERR sticky err", {31'd0, err}, 32'd1);
    reset = 1'b1;
    #1;
    chk("ERR cleared by reset", {31'd0, err}, 32'd0);
    chk("ERR reset state", {29'd0, state}, 32'd0);
`else
    repeat (20) @(negedge clk);
    #1;
    chk("no timeout state", {29'd0, state}, 32'd4);
    chk("no timeout err", {31'd0, err}, 32'd0);
    chk("no timeout MemRead", {31'd0, MemRead}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
